regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (write_register/write_value) between the ALU writeback

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regwr_starve_counter.sv | 23 ++
 rtl/regfile_write_arbiter.sv | 94 +++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request record used by the write-port arbiter.
package regfile_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 5;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wr_req_t;

  // r0 and unimplemented indices are "null" destinations that never reach the register file
  function automatic logic real_rd(input logic [REG_IDX_W-1:0] rd);
    return (rd != REG_ZERO) && (int'(rd) < NUM_REGS);
  endfunction
endpackage

// File: rtl/regwr_starve_counter.sv
// Saturating count of consecutive ALU conflict losses; at_limit forces the next conflict to the ALU.
module regwr_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);
  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && !at_limit)
      count <= count + 4'd1;
  end

  assign at_limit = (count == 4'(LIMIT));
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and LSU load data.
// Define REGWR_SCOREBOARD_EN to track outstanding loads and stall ALU writes to pending registers.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic [REG_IDX_W-1:0] write_register,
`ifdef REGWR_SCOREBOARD_EN
  input  logic                 lsu_issue,
  input  logic [REG_IDX_W-1:0] lsu_issue_rd,
  output logic [NUM_REGS-1:0]  rd_pending,
`endif
  output logic [XLEN-1:0]      write_value
);
  logic    alu_real, lsu_real, alu_hazard, alu_cand, conflict;
  logic    grant_alu, grant_lsu, at_limit;
  wr_req_t wr_q;

`ifdef REGWR_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_next;

  always_comb begin
    alu_hazard = 1'b0;
    for (int i = 1; i < NUM_REGS; i++)
      if (alu_rd == REG_IDX_W'(i) && rd_pending[i])
        alu_hazard = 1'b1;
  end

  // Clear on the accepting edge first, so a same-edge reissue to that rd keeps the bit set
  always_comb begin
    pending_next = rd_pending;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (grant_lsu && lsu_rd == REG_IDX_W'(i))
        pending_next[i] = 1'b0;
      if (lsu_issue && lsu_issue_rd == REG_IDX_W'(i))
        pending_next[i] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_pending <= '0;
    else
      rd_pending <= pending_next;
  end
`else
  assign alu_hazard = 1'b0;
`endif

  always_comb begin
    alu_real  = alu_valid && real_rd(alu_rd);
    lsu_real  = lsu_valid && real_rd(lsu_rd);
    alu_cand  = alu_real && !alu_hazard;
    conflict  = alu_cand && lsu_real;
    grant_alu = alu_cand && (!lsu_real || at_limit);
    grant_lsu = lsu_real && !(conflict && at_limit);
    alu_ready = (alu_valid && !real_rd(alu_rd)) || grant_alu;
    lsu_ready = (lsu_valid && !real_rd(lsu_rd)) || grant_lsu;
  end

  regwr_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!alu_valid || alu_ready),
    .inc      (conflict),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_q <= '0;
    else if (grant_lsu)
      wr_q <= '{rd: lsu_rd, data: lsu_data};
    else if (grant_alu)
      wr_q <= '{rd: alu_rd, data: alu_data};
    else
      wr_q <= '0;
  end

  assign write_register = wr_q.rd;
  assign write_value    = wr_q.data;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the register-file write arbiter against a rule-level model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [REG_IDX_W-1:0] alu_rd, lsu_rd, write_register;
  logic [XLEN-1:0]      alu_data, lsu_data, write_value;
`ifdef REGWR_SCOREBOARD_EN
  logic                 lsu_issue;
  logic [REG_IDX_W-1:0] lsu_issue_rd;
  logic [NUM_REGS-1:0]  rd_pending;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .lsu_rd         (lsu_rd),
    .lsu_data       (lsu_data),
    .write_register (write_register),
`ifdef REGWR_SCOREBOARD_EN
    .lsu_issue      (lsu_issue),
    .lsu_issue_rd   (lsu_issue_rd),
    .rd_pending     (rd_pending),
`endif
    .write_value    (write_value)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Rule-level model state for the randomized phase
  int          starve;
  logic        cav, clv, a_acc, l_acc, a_real, l_real;
  logic [4:0]  card, clrd, exp_rd;
  logic [31:0] cad, cld, exp_val;

  initial begin
    rst_n = 1'b0;
`ifdef REGWR_SCOREBOARD_EN
    lsu_issue = 1'b0;
    lsu_issue_rd = '0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    #10;
    checkOutput("reset_wr_reg", 32'(write_register), 32'd0);
    checkOutput("reset_wr_val", write_value, 32'd0);
    #2 rst_n = 1'b1;
    tick;

    // ALU alone, rd=3
    applyStimulus(1, 3, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("alu_only_ready", 32'(alu_ready), 32'd1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("alu_only_wr_reg", 32'(write_register), 32'd3);
    checkOutput("alu_only_wr_val", write_value, 32'hDEADBEEF);
    tick;
    checkOutput("idle_wr_reg", 32'(write_register), 32'd0);
    checkOutput("idle_wr_val", write_value, 32'd0);

    // Asynchronous reset mid-cycle while a write is on the port and another grant is pending
    applyStimulus(1, 3, 32'h12345678, 0, 0, 0);
    tick;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_wr_reg", 32'(write_register), 32'd0);
    checkOutput("async_rst_wr_val", write_value, 32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick;

    // Sustained conflict: LSU x4 then ALU, repeating
    applyStimulus(1, 2, 32'hA0A0A0A0, 1, 1, 32'h50505050);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("conflict_lsu_ready_%0d", i), 32'(lsu_ready), (i % 5 == 4) ? 32'd0 : 32'd1);
      checkOutput($sformatf("conflict_alu_ready_%0d", i), 32'(alu_ready), (i % 5 == 4) ? 32'd1 : 32'd0);
      tick;
      checkOutput($sformatf("conflict_wr_reg_%0d", i), 32'(write_register), (i % 5 == 4) ? 32'd2 : 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick;

    // Null ALU destinations alongside a real LSU write
    applyStimulus(1, 0, 32'h11111111, 1, 2, 32'h22222222);
    checkOutput("null_r0_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("null_r0_lsu_ready", 32'(lsu_ready), 32'd1);
    tick;
    applyStimulus(1, 7, 32'h33333333, 0, 0, 0);
    checkOutput("null_r0_wr_reg", 32'(write_register), 32'd2);
    checkOutput("null_r0_wr_val", write_value, 32'h22222222);
    checkOutput("null_hi_alu_ready", 32'(alu_ready), 32'd1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("null_hi_wr_reg", 32'(write_register), 32'd0);
    tick;

    // Randomized traffic with held requests, checked against the arbitration rules
    starve = 0;
    cav = 1'b0; clv = 1'b0; a_acc = 1'b1; l_acc = 1'b1;
    card = '0; clrd = '0; cad = '0; cld = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cav || a_acc) begin
        cav = ($urandom_range(0, 3) != 0);
        card = 5'($urandom_range(0, 7));
        cad = $urandom;
      end
      if (!clv || l_acc) begin
        clv = ($urandom_range(0, 3) != 0);
        clrd = 5'($urandom_range(0, 7));
        cld = $urandom;
      end
      applyStimulus(cav, card, cad, clv, clrd, cld);

      a_real = cav && card >= 1 && int'(card) < NUM_REGS;
      l_real = clv && clrd >= 1 && int'(clrd) < NUM_REGS;
      a_acc = cav && (!a_real || !l_real || starve == STARVE_LIMIT);
      l_acc = clv && (!l_real || !a_real || starve != STARVE_LIMIT);
      if (l_real && l_acc) begin
        exp_rd = clrd; exp_val = cld;
      end else if (a_real && a_acc) begin
        exp_rd = card; exp_val = cad;
      end else begin
        exp_rd = '0; exp_val = '0;
      end
      if (!cav || a_acc)
        starve = 0;
      else if (a_real && l_real)
        starve = starve + 1;

      if (cav) checkOutput($sformatf("rand_alu_ready_%0d", n), 32'(alu_ready), 32'(a_acc));
      if (clv) checkOutput($sformatf("rand_lsu_ready_%0d", n), 32'(lsu_ready), 32'(l_acc));
      tick;
      checkOutput($sformatf("rand_wr_reg_%0d", n), 32'(write_register), 32'(exp_rd));
      checkOutput($sformatf("rand_wr_val_%0d", n), write_value, exp_val);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick;

`ifdef REGWR_SCOREBOARD_EN
    // Load to r4 outstanding: ALU write to r4 must wait behind the LSU write
    lsu_issue = 1'b1; lsu_issue_rd = 5'd4;
    tick;
    lsu_issue_rd = 5'd0;
    tick;
    lsu_issue_rd = 5'd6;
    tick;
    lsu_issue = 1'b0;
    checkOutput("sb_pending_set", 32'(rd_pending), 32'h10);
    applyStimulus(1, 4, 32'hAAAA0004, 0, 0, 0);
    checkOutput("sb_alu_stalled", 32'(alu_ready), 32'd0);
    tick;
    checkOutput("sb_stall_no_write", 32'(write_register), 32'd0);
    applyStimulus(1, 4, 32'hAAAA0004, 1, 4, 32'h5555AAAA);
    checkOutput("sb_lsu_ready", 32'(lsu_ready), 32'd1);
    checkOutput("sb_alu_still_stalled", 32'(alu_ready), 32'd0);
    tick;
    checkOutput("sb_pending_clear", 32'(rd_pending), 32'h0);
    checkOutput("sb_first_wr_reg", 32'(write_register), 32'd4);
    checkOutput("sb_first_wr_val", write_value, 32'h5555AAAA);
    applyStimulus(1, 4, 32'hAAAA0004, 0, 0, 0);
    checkOutput("sb_alu_released", 32'(alu_ready), 32'd1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sb_second_wr_reg", 32'(write_register), 32'd4);
    checkOutput("sb_second_wr_val", write_value, 32'hAAAA0004);
    tick;

    // Reissue to r2 on the edge its previous load is accepted keeps r2 pending
    lsu_issue = 1'b1; lsu_issue_rd = 5'd2;
    tick;
    checkOutput("sb_r2_pending", 32'(rd_pending), 32'h4);
    applyStimulus(0, 0, 0, 1, 2, 32'h0000C0DE);
    checkOutput("sb_r2_lsu_ready", 32'(lsu_ready), 32'd1);
    tick;
    lsu_issue = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sb_set_wins", 32'(rd_pending), 32'h4);
    checkOutput("sb_r2_wr_reg", 32'(write_register), 32'd2);
    tick;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
